imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: maximum consecutive fetch grants while a debug request waits.
REQ-002 Parameter DEPTH, default 128: instruction memory depth in words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 f_req  input  1  fetch port request, from the IF stage.
REQ-006 f_addr  input  32  fetch word address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  f_rdata valid, one cycle after f_gnt.
REQ-009 f_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  debug/loader read request.
REQ-011 d_addr  input  32  debug word address.
REQ-012 d_gnt  output  1  debug request accepted this cycle.
REQ-013 d_rvalid  output  1  d_rdata valid, one cycle after d_gnt.
REQ-014 d_rdata  output  32  debug read data.
REQ-015 mem_addr  output  32  address driven to the combinational-read instruction memory.
REQ-016 mem_data  input  32  memory read word, valid in the same cycle as mem_addr.
REQ-017 addr_err  output  1  pulses together with rvalid when the served address was >= DEPTH.
REQ-018 f_stall  output  1  high while f_req=1 and f_gnt=0.

Function
- REQ-019 At most one of f_gnt and d_gnt SHALL be high in any cycle; both are combinational from the req inputs and registered state.
- REQ-020 Only f_req=1: f_gnt=1. Only d_req=1: d_gnt=1. Neither: no grant, mem_addr holds its previous value.
- REQ-021 Both requests high: fetch wins unless streak == MAX_STREAK, in which case debug wins.
- REQ-022 streak is a saturating counter of width clog2(MAX_STREAK+1). It increments on a fetch grant while d_req=1, clears on a debug grant or when d_req=0, and never exceeds MAX_STREAK.
- REQ-023 mem_addr SHALL equal the granted port's address in the grant cycle.
- REQ-024 Latency: on the edge after a grant, the arbiter registers the data into the granted port's rdata and asserts that port's rvalid for exactly one cycle. Back-to-back grants give back-to-back rvalid.
- REQ-025 FSM state register owner, with states IDLE, SERVE_F and SERVE_D. It takes SERVE_F after a fetch grant, SERVE_D after a debug grant, and IDLE after a cycle with no grant. owner drives the rvalid outputs.
- REQ-026 Requesters SHALL hold req and addr stable until granted. An unrequested port SHALL never see gnt or rvalid.
- REQ-027 Address >= DEPTH: the grant proceeds normally, the port's rdata is registered as 32'h0, and addr_err=1 in the rvalid cycle. Boundary values: DEPTH-1 is valid, DEPTH is an error.
- REQ-028 rdata SHALL hold its last value when rvalid=0.
- REQ-029 A request dropped before its grant is discarded with no side effect.

Reset
- REQ-030 While rst=0: all gnt, rvalid, addr_err and f_stall outputs are 0, both rdata are 0, mem_addr is 0, owner is IDLE, streak is 0.
- REQ-031 Reset asserted mid-access cancels the pending rvalid; it does not reappear after release.
- REQ-032 The first grant may occur in the first cycle after rst deasserts.

Structure
- REQ-033 A shared package holds the owner state encoding (IDLE=2'd0, SERVE_F=2'd1, SERVE_D=2'd2), the default DEPTH and the 32-bit word width constant.
- REQ-034 Sub-module streak_counter (saturating, clear and increment inputs) holds the starvation logic. All other logic stays flat.

Verification
- REQ-035 f_req=1, f_addr=5 with MEM[5]=32'hDEADBEEF -> f_gnt same cycle; next cycle f_rvalid=1, f_rdata=32'hDEADBEEF.
- REQ-036 f_req and d_req held high together, MAX_STREAK=4 -> grant pattern F,F,F,F,D repeating; d_gnt at cycle 5.
- REQ-037 d_req=1, d_addr=128 -> d_rvalid=1, d_rdata=0, addr_err=1 for one cycle. d_addr=127 -> addr_err=0.
- REQ-038 Fetch grant at cycle n, rst=0 at cycle n+1 before the edge -> f_rvalid never asserts; all outputs 0 until release.
- REQ-039 Consecutive fetches at addresses 0,1,2 -> f_rvalid high for three consecutive cycles with the matching data; f_stall=0 throughout.
- REQ-040 d_req=1 only, then d_req drops before f_req rises -> streak=0 and no spurious d_rvalid.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
// Shared definitions for the instruction-memory arbiter: the owner state
// encoding, the default memory depth and the word width.
package imem_arbiter_pkg;

    localparam int WORD_W        = 32;
    localparam int DEFAULT_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_F = 2'd1,
        SERVE_D = 2'd2
    } owner_t;

endpackage

// File: rtl/imem_arbiter_streak.sv
// streak_counter
// Saturating counter that tracks consecutive fetch grants taken while a
// debug request is waiting. Clear has priority over increment.
// Ports:
//   clk, rst   clock, async active-low reset
//   clr        return the count to zero
//   inc        count one more fetch grant (held at MAX once reached)
//   count      current streak value
module streak_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Two-port arbiter in front of a combinational-read instruction memory.
// The fetch port has priority, but after MAX_STREAK back-to-back fetch wins
// against a waiting debug request the debug port gets one grant.
// Read data is registered into the granted port on the edge after the grant.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no grant last cycle, no rvalid this cycle
// SERVE_F | fetch granted last cycle, f_rvalid this cycle
// SERVE_D | debug granted last cycle, d_rvalid this cycle
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   f_req, f_addr                 fetch request / word address
//   f_gnt, f_rvalid, f_rdata      fetch grant, data valid, data
//   f_stall                       fetch waiting for a grant
//   d_req, d_addr                 debug request / word address
//   d_gnt, d_rvalid, d_rdata      debug grant, data valid, data
//   mem_addr, mem_data            memory address out, read word in
//   addr_err                      served address was out of range
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [WORD_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [WORD_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              addr_err,
    output logic              f_stall
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    owner_t            owner;
    logic [SW-1:0]     streak;
    logic [WORD_W-1:0] addr_q;
    logic              at_limit;
    logic              in_range;
    logic [WORD_W-1:0] served;

    assign at_limit = (streak == SW'(MAX_STREAK));

    // Grants are gated by rst so that nothing is granted while reset is held.
    assign f_gnt   = rst && f_req && !(d_req && at_limit);
    assign d_gnt   = rst && d_req && !f_gnt;
    assign f_stall = rst && f_req && !f_gnt;

    // With no grant the memory keeps seeing the last granted address.
    assign mem_addr = f_gnt ? f_addr : (d_gnt ? d_addr : addr_q);
    assign in_range = (mem_addr < WORD_W'(DEPTH));
    assign served   = in_range ? mem_data : '0;

    assign f_rvalid = (owner == SERVE_F);
    assign d_rvalid = (owner == SERVE_D);

    streak_counter #(
        .MAX (MAX_STREAK),
        .W   (SW)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (d_gnt || !d_req),
        .inc   (f_gnt && d_req),
        .count (streak)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= IDLE;
            addr_err <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
            addr_q   <= '0;
        end else begin
            addr_err <= (f_gnt || d_gnt) && !in_range;
            if (f_gnt) begin
                owner   <= SERVE_F;
                f_rdata <= served;
                addr_q  <= mem_addr;
            end else if (d_gnt) begin
                owner   <= SERVE_D;
                d_rdata <= served;
                addr_q  <= mem_addr;
            end else begin
                owner   <= IDLE;
            end
        end
    end

endmodule
